// File: rtl/level_decode_stream.sv
// CAVLC level decoder for H.264 residual blocks.
// Decodes trailing-one signs and level_prefix/level_suffix codes from an
// MSB-first bitstream window and emits one signed level per cycle over a
// valid/ready handshake. The bit count to consume is reported in the same
// cycle; the decoded level appears on the registered outputs one cycle later.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for Start; bad TotalCoeff raises Error here
// S_T1    | decoding trailing-one sign bits (one bit per level)
// S_LEVEL | decoding prefix/suffix level codes with suffixLength adaptation
// S_DONE  | all levels decoded; Done pulses once the last level is taken
module level_decode_stream #(
  parameter int WIN_W     = 32,
  parameter int LEVEL_W   = 16,
  parameter int MAX_COEFF = 16
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               Start,
  input  logic [4:0]         TotalCoeff,
  input  logic [1:0]         TrailingOnes,
  input  logic [WIN_W-1:0]   Bits,
  input  logic               BitsValid,
  output logic               ShiftEn,
  output logic [5:0]         NumShift,
  output logic [LEVEL_W-1:0] LevelOut,
  output logic [4:0]         LevelIdx,
  output logic               LevelValid,
  input  logic               LevelReady,
  output logic               Busy,
  output logic               Done,
  output logic               Error
);

  typedef enum logic [1:0] {S_IDLE, S_T1, S_LEVEL, S_DONE} state_t;

  localparam logic [5:0]  MAX_TC  = 6'(MAX_COEFF);
  localparam logic [31:0] MAX_POS = 32'((64'd1 << (LEVEL_W - 1)) - 64'd1);

  state_t             state, state_nxt;
  logic [2:0]         sl, sl_nxt;
  logic [4:0]         idx;
  logic [4:0]         total;
  logic [1:0]         t1;
  logic               first_lvl;
  logic [LEVEL_W-1:0] level_q;
  logic [4:0]         level_idx_q;
  logic               level_valid_q;

  logic               adv;
  logic               accept;
  logic               load;
  logic               emit;
  logic               shift_en;
  logic [5:0]         num_shift;
  logic [LEVEL_W-1:0] emit_level;
  logic               done_p;
  logic               err_p;

  logic [4:0]         prefix;
  logic [3:0]         suffix_size;
  logic [WIN_W-1:0]   after_prefix;
  logic [11:0]        suffix_raw;
  logic [11:0]        suffix;
  logic [5:0]         lvl_shift;
  logic [13:0]        level_code;
  logic [13:0]        mag;
  logic               lvl_neg;
  logic               ovf;
  logic [LEVEL_W-1:0] mag_w;
  logic [LEVEL_W-1:0] lvl_val;
  logic [2:0]         sl_base;
  logic [13:0]        thresh;
  logic [2:0]         sl_upd;
  logic [5:0]         idx_p1;
  logic               blk_last;
  logic               t1_last;
  logic               bad_tc;
  logic               init_sl;

  assign accept   = level_valid_q && LevelReady;
  assign adv      = BitsValid && (!level_valid_q || LevelReady);
  assign idx_p1   = {1'b0, idx} + 6'd1;
  assign blk_last = idx_p1 >= {1'b0, total};
  assign t1_last  = idx_p1 >= {4'b0, t1};
  assign bad_tc   = {1'b0, TotalCoeff} > MAX_TC;
  assign init_sl  = (TotalCoeff > 5'd10) && (TrailingOnes < 2'd3);

  // Leading-zero count over the first 16 window bits; 16 means no marker found.
  always_comb begin
    prefix = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (Bits[WIN_W-16+i]) prefix = 5'(15 - i);
    end
  end

  // Suffix extraction, level code assembly and suffixLength adaptation.
  always_comb begin
    if (prefix == 5'd15)                     suffix_size = 4'd12;
    else if (prefix == 5'd14 && sl == 3'd0)  suffix_size = 4'd4;
    else                                     suffix_size = {1'b0, sl};
    after_prefix = Bits << (prefix + 5'd1);
    suffix_raw   = after_prefix[WIN_W-1 -: 12];
    suffix       = suffix_raw >> (4'd12 - suffix_size);
    lvl_shift    = 6'(prefix) + 6'd1 + 6'(suffix_size);
    level_code   = (14'(prefix[3:0]) << sl) + 14'(suffix)
                 + ((prefix == 5'd15 && sl == 3'd0) ? 14'd15 : 14'd0)
                 + ((first_lvl && t1 < 2'd3) ? 14'd2 : 14'd0);
    lvl_neg      = level_code[0];
    mag          = lvl_neg ? ((level_code + 14'd1) >> 1) : ((level_code + 14'd2) >> 1);
    ovf          = lvl_neg ? (32'(mag) > MAX_POS + 32'd1) : (32'(mag) > MAX_POS);
    mag_w        = LEVEL_W'(mag);
    lvl_val      = lvl_neg ? (~mag_w + LEVEL_W'(1)) : mag_w;
    sl_base      = (sl == 3'd0) ? 3'd1 : sl;
    thresh       = 14'd3 << (sl_base - 3'd1);
    sl_upd       = ((mag > thresh) && (sl_base < 3'd6)) ? sl_base + 3'd1 : sl_base;
  end

  // Next-state, shift request and level emission.
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    emit       = 1'b0;
    shift_en   = 1'b0;
    num_shift  = 6'd0;
    emit_level = '0;
    done_p     = 1'b0;
    err_p      = 1'b0;
    sl_nxt     = sl;
    case (state)
      S_IDLE: begin
        if (Start) begin
          if (bad_tc) begin
            err_p = 1'b1;
          end else begin
            load = 1'b1;
            if (TotalCoeff == 5'd0)        state_nxt = S_DONE;
            else if (TrailingOnes != 2'd0) state_nxt = S_T1;
            else                           state_nxt = S_LEVEL;
          end
        end
      end
      S_T1: begin
        if (adv) begin
          shift_en   = 1'b1;
          num_shift  = 6'd1;
          emit       = 1'b1;
          emit_level = Bits[WIN_W-1] ? {LEVEL_W{1'b1}} : LEVEL_W'(1);
          if (blk_last)     state_nxt = S_DONE;
          else if (t1_last) state_nxt = S_LEVEL;
        end
      end
      S_LEVEL: begin
        if (adv) begin
          if (prefix == 5'd16 || ovf) begin
            err_p     = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            shift_en   = 1'b1;
            num_shift  = lvl_shift;
            emit       = 1'b1;
            emit_level = lvl_val;
            sl_nxt     = sl_upd;
            if (blk_last) state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!level_valid_q || LevelReady) begin
          done_p    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, block context and registered level output.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state         <= S_IDLE;
      sl            <= 3'd0;
      idx           <= 5'd0;
      total         <= 5'd0;
      t1            <= 2'd0;
      first_lvl     <= 1'b0;
      level_q       <= '0;
      level_idx_q   <= 5'd0;
      level_valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sl        <= init_sl ? 3'd1 : 3'd0;
        idx       <= 5'd0;
        total     <= TotalCoeff;
        t1        <= TrailingOnes;
        first_lvl <= 1'b1;
      end
      if (emit) begin
        level_q       <= emit_level;
        level_idx_q   <= idx;
        level_valid_q <= 1'b1;
        idx           <= idx_p1[4:0];
        if (state == S_LEVEL) begin
          first_lvl <= 1'b0;
          sl        <= sl_nxt;
        end
      end else if (accept || err_p) begin
        level_valid_q <= 1'b0;
      end
    end
  end

  assign ShiftEn    = shift_en;
  assign NumShift   = num_shift;
  assign LevelOut   = level_q;
  assign LevelIdx   = level_idx_q;
  assign LevelValid = level_valid_q;
  assign Busy       = (state != S_IDLE);
  assign Done       = done_p;
  assign Error      = err_p;

endmodule

// File: tb/tb_level_decode_stream.sv
// Directed bench for level_decode_stream: a bit-accurate stream model feeds
// the window, expected shifts and levels are queued up front and popped as
// the decoder consumes bits and hands out levels.
module tb_level_decode_stream;

  localparam int WIN_W   = 32;
  localparam int LEVEL_W = 16;

  typedef struct {
    logic [LEVEL_W-1:0] lvl;
    logic [4:0]         idx;
  } exp_t;

  logic               Clk = 1'b0;
  logic               nReset = 1'b0;
  logic               Start = 1'b0;
  logic [4:0]         TotalCoeff = 5'd0;
  logic [1:0]         TrailingOnes = 2'd0;
  logic [WIN_W-1:0]   Bits;
  logic               BitsValid = 1'b1;
  logic               ShiftEn;
  logic [5:0]         NumShift;
  logic [LEVEL_W-1:0] LevelOut;
  logic [4:0]         LevelIdx;
  logic               LevelValid;
  logic               LevelReady = 1'b1;
  logic               Busy;
  logic               Done;
  logic               Error;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [511:0] stream = '0;
  logic [511:0] stream_sh;
  int           ptr = 0;
  int           wptr = 0;
  logic         sh_req = 1'b0;
  logic [5:0]   sh_n = 6'd0;

  exp_t q_lvl[$];
  int   q_sh[$];

  level_decode_stream #(.WIN_W(WIN_W), .LEVEL_W(LEVEL_W), .MAX_COEFF(16)) dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .TotalCoeff(TotalCoeff),
    .TrailingOnes(TrailingOnes), .Bits(Bits), .BitsValid(BitsValid),
    .ShiftEn(ShiftEn), .NumShift(NumShift), .LevelOut(LevelOut),
    .LevelIdx(LevelIdx), .LevelValid(LevelValid), .LevelReady(LevelReady),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  assign stream_sh = stream << ptr;
  assign Bits      = stream_sh[511 -: WIN_W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture the shift request mid-cycle and check it against the queue.
  always @(negedge Clk) begin
    sh_req = ShiftEn;
    sh_n   = NumShift;
    if (ShiftEn) begin
      chk("shift_q_nonempty", 32'(q_sh.size() != 0), 32'd1);
      if (q_sh.size() != 0) chk("num_shift", 32'(NumShift), 32'(q_sh.pop_front()));
    end
  end

  // Advance the stream pointer just after the edge that consumed the bits.
  always @(posedge Clk) begin
    #1;
    if (sh_req) begin
      ptr    = ptr + int'(sh_n);
      sh_req = 1'b0;
    end
  end

  // Level scoreboard and Done bookkeeping.
  always @(negedge Clk) begin
    exp_t e;
    if (LevelValid && LevelReady) begin
      chk("level_q_nonempty", 32'(q_lvl.size() != 0), 32'd1);
      if (q_lvl.size() != 0) begin
        e = q_lvl.pop_front();
        chk("level_out", 32'(LevelOut), 32'(e.lvl));
        chk("level_idx", 32'(LevelIdx), 32'(e.idx));
      end
    end
    if (Done) begin
      done_cnt++;
      chk("done_lvl_q_empty", 32'(q_lvl.size()), 32'd0);
      chk("done_sh_q_empty", 32'(q_sh.size()), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic new_stream();
    stream = '0;
    ptr    = 0;
    wptr   = 0;
  endtask

  task automatic put(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      stream[511 - wptr] = v[i];
      wptr++;
    end
  endtask

  task automatic exp_level(input int v, input int i);
    exp_t e;
    e.lvl = LEVEL_W'(v);
    e.idx = 5'(i);
    q_lvl.push_back(e);
  endtask

  task automatic start_blk(input int tc, input int t1);
    Start        = 1'b1;
    TotalCoeff   = 5'(tc);
    TrailingOnes = 2'(t1);
    tick(1);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int s;
    logic seen;
    s    = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge Clk);
      #1;
      if (done_cnt != s) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [LEVEL_W-1:0] held;

    #3;
    chk("rst_level_valid", 32'(LevelValid), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_shift", {25'd0, ShiftEn, NumShift}, 32'd0);
    chk("rst_done_err", {30'd0, Done, Error}, 32'd0);
    chk("rst_level_out", 32'(LevelOut), 32'd0);
    tick(2);
    nReset = 1'b1;
    tick(2);

    // TC=3, T1=1: sign bit 1, then codes "1" and "0011".
    new_stream();
    put(32'b110011, 6);
    q_sh.push_back(1); q_sh.push_back(1); q_sh.push_back(4);
    exp_level(-1, 0); exp_level(2, 1); exp_level(-3, 2);
    start_blk(3, 1);
    chk("t1_busy", 32'(Busy), 32'd1);
    wait_done("t1_done", 20);
    tick(1);
    chk("t1_idle", 32'(Busy), 32'd0);

    // prefix 14 with sL=0 uses a 4-bit suffix.
    new_stream();
    put(32'd0, 14); put(32'd1, 1); put(32'b0101, 4);
    q_sh.push_back(19);
    exp_level(-11, 0);
    start_blk(1, 0);
    wait_done("p14_done", 20);
    tick(1);

    // prefix 15 escape with a 12-bit suffix.
    new_stream();
    put(32'd0, 15); put(32'd1, 1); put(32'h00A, 12);
    q_sh.push_back(28);
    exp_level(22, 0);
    start_blk(1, 0);
    wait_done("p15_done", 20);
    tick(1);

    // TC=12: sL starts at 1, +5 bumps it to 2, later codes carry 2-bit suffixes.
    new_stream();
    put(32'b00010, 5); q_sh.push_back(5); exp_level(5, 0);
    put(32'b111, 3);   q_sh.push_back(3); exp_level(-2, 1);
    for (int i = 2; i < 12; i++) begin
      put(32'b100, 3); q_sh.push_back(3); exp_level(1, i);
    end
    start_blk(12, 0);
    tick(3);
    LevelReady = 1'b0;
    @(negedge Clk);
    chk("stall_valid", 32'(LevelValid), 32'd1);
    held = LevelOut;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge Clk);
      chk("stall_shift", 32'(ShiftEn), 32'd0);
      chk("stall_hold", 32'(LevelOut), 32'(held));
    end
    @(posedge Clk);
    #1;
    LevelReady = 1'b1;
    wait_done("tc12_done", 40);
    tick(1);

    // TC=0: Done in the cycle after Start, no level.
    new_stream();
    start_blk(0, 0);
    @(negedge Clk);
    chk("tc0_done", 32'(Done), 32'd1);
    chk("tc0_no_level", 32'(LevelValid), 32'd0);
    tick(1);
    chk("tc0_idle", 32'(Busy), 32'd0);

    // 16 leading zeros: Error, no shift, back to idle.
    new_stream();
    start_blk(1, 0);
    @(negedge Clk);
    chk("p16_error", 32'(Error), 32'd1);
    chk("p16_no_shift", 32'(ShiftEn), 32'd0);
    tick(1);
    chk("p16_idle", 32'(Busy), 32'd0);
    chk("p16_no_level", 32'(LevelValid), 32'd0);

    // TotalCoeff above MAX_COEFF rejected at Start.
    Start = 1'b1;
    TotalCoeff = 5'd17;
    TrailingOnes = 2'd0;
    @(negedge Clk);
    chk("bad_tc_error", 32'(Error), 32'd1);
    tick(1);
    Start = 1'b0;
    chk("bad_tc_idle", 32'(Busy), 32'd0);

    // Reset in the middle of a stalled block.
    new_stream();
    put(32'b110011, 6);
    q_sh.push_back(1);
    LevelReady = 1'b0;
    start_blk(3, 1);
    tick(2);
    chk("mid_busy", 32'(Busy), 32'd1);
    chk("mid_valid", 32'(LevelValid), 32'd1);
    nReset = 1'b0;
    #2;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_valid", 32'(LevelValid), 32'd0);
    chk("abort_outs", {29'd0, ShiftEn, Done, Error}, 32'd0);
    q_lvl.delete();
    tick(1);
    nReset = 1'b1;
    LevelReady = 1'b1;
    tick(3);
    chk("post_abort_idle", 32'(Busy), 32'd0);
    chk("final_sh_q_empty", 32'(q_sh.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
